// File: rtl/stack_unit.sv
// LIFO responder for the core's stack port: single-cycle push/pop, registered pop data,
// registered full/empty/count and sticky overflow/underflow flags.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_in_i,
    input  logic             clear_err_i,
    output logic [WIDTH-1:0] data_out_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o,
    output logic             overflow_o,
    output logic             underflow_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0]      sp_q, sp_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             we_s;
    logic [AW-1:0]    waddr_s;
    logic [AW-1:0]    top_idx_s;
    logic             ovf_evt_s;
    logic             unf_evt_s;

    // Top index wraps to DEPTH-1 when the stack is full (low bits of sp are zero then).
    assign top_idx_s = sp_q[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};

    // Next-state decode for pointer, pop data, write strobe and error flags.
    always_comb begin
        sp_d      = sp_q;
        dout_d    = dout_q;
        we_s      = 1'b0;
        waddr_s   = sp_q[AW-1:0];
        ovf_evt_s = 1'b0;
        unf_evt_s = 1'b0;
        case ({push_i, pop_i})
            2'b10: begin
                if (full_q) begin
                    ovf_evt_s = 1'b1;
                end else begin
                    we_s = 1'b1;
                    sp_d = sp_q + ONE_CNT;
                end
            end
            2'b01: begin
                if (empty_q) begin
                    unf_evt_s = 1'b1;
                end else begin
                    dout_d = mem[top_idx_s];
                    sp_d   = sp_q - ONE_CNT;
                end
            end
            2'b11: begin
                if (empty_q) begin
                    dout_d = data_in_i;
                end else begin
                    dout_d  = mem[top_idx_s];
                    we_s    = 1'b1;
                    waddr_s = top_idx_s;
                end
            end
            default: begin
                sp_d = sp_q;
            end
        endcase
        // A same-edge error event wins over clear_err.
        ovf_d   = (clear_err_i ? 1'b0 : ovf_q) | ovf_evt_s;
        unf_d   = (clear_err_i ? 1'b0 : unf_q) | unf_evt_s;
        full_d  = (sp_d == FULL_CNT);
        empty_d = (sp_d == '0);
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            sp_q    <= '0;
            dout_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            dout_q  <= dout_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (resetN && we_s) begin
            mem[waddr_s] <= data_in_i;
        end
    end

    assign data_out_o  = dout_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign count_o     = sp_q;
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;

endmodule
